// File: rtl/irrigation_valve_scheduler_pkg.sv
// Shared definitions for the irrigation valve scheduler and its timebase companions:
// state encoding, zone index width and default ON/GAP tick durations.
package irrigation_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_OPEN   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GRANT  = ST_GRANT,
    OPEN   = ST_OPEN,
    SETTLE = ST_SETTLE
  } state_e;

  localparam int ZONE_ID_W     = 3;
  localparam int DEF_ON_TICKS  = 20;
  localparam int DEF_GAP_TICKS = 3;

endpackage

// File: rtl/irrigation_valve_scheduler_tick_downcounter.sv
// Loadable down-counter advanced only by timebase ticks; shared by the ON and GAP phases.
// Saturates at zero and flags it combinationally so the owner can act on the same tick.
module tick_downcounter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/irrigation_valve_scheduler.sv
// Round-robin scheduler sharing one valve/pump path between N_ZONES irrigation zones:
// grant, hold the valve open for ON_TICKS ticks, then keep all valves shut for GAP_TICKS.
module irrigation_valve_scheduler
  import irrigation_pkg::*;
#(
  parameter int N_ZONES   = 4,
  parameter int CNT_W     = 8,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [N_ZONES-1:0]   req,
  input  logic                 water_ok,
  output logic [N_ZONES-1:0]   valve_en,
  output logic                 busy,
  output logic [ZONE_ID_W-1:0] zone_id,
  output logic [N_ZONES-1:0]   done,
  output logic                 abort
);

  localparam logic [CNT_W-1:0]     ON_LOAD  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0]     GAP_LOAD = (GAP_TICKS == 0) ? '0 : CNT_W'(GAP_TICKS - 1);
  localparam logic [N_ZONES-1:0]   ONE      = N_ZONES'(1);
  localparam logic [ZONE_ID_W-1:0] LAST     = ZONE_ID_W'(N_ZONES - 1);

  state_e               state;
  logic [ZONE_ID_W-1:0] rr_ptr;

  // Returns {found, index} of the first requesting zone at or after ptr, wrapping around.
  function automatic logic [ZONE_ID_W:0] rr_pick(input logic [N_ZONES-1:0]   r,
                                                 input logic [ZONE_ID_W-1:0] ptr);
    logic [ZONE_ID_W:0] res;
    int                 idx;
    res = '0;
    for (int i = N_ZONES - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_ZONES;
      if (((r >> idx) & ONE) != '0) res = {1'b1, ZONE_ID_W'(idx)};
    end
    return res;
  endfunction

  logic [ZONE_ID_W:0]   pick;
  logic                 pick_ok;
  logic [ZONE_ID_W-1:0] pick_id;
  logic                 cnt_zero;
  logic                 grant_now;
  logic                 close_now;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic [CNT_W-1:0]     cnt_val;

  assign pick    = rr_pick(req, rr_ptr);
  assign pick_ok = pick[ZONE_ID_W];
  assign pick_id = pick[ZONE_ID_W-1:0];

  // A water fault closes the valve regardless of tick; otherwise the last tick at zero does.
  assign grant_now = (state == GRANT) && water_ok && pick_ok;
  assign close_now = (state == OPEN) && (!water_ok || (tick && cnt_zero));
  assign cnt_load  = grant_now || close_now;
  assign cnt_val   = grant_now ? ON_LOAD : GAP_LOAD;
  assign cnt_dec   = tick && ((state == OPEN) || (state == SETTLE));

  tick_downcounter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valve_en <= '0;
      busy     <= 1'b0;
      zone_id  <= '0;
      done     <= '0;
      abort    <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      done  <= '0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (water_ok && (req != '0)) begin
            state <= GRANT;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (grant_now) begin
            state    <= OPEN;
            zone_id  <= pick_id;
            rr_ptr   <= (pick_id == LAST) ? '0 : pick_id + ZONE_ID_W'(1);
            valve_en <= ONE << pick_id;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        OPEN: begin
          if (close_now) begin
            valve_en <= '0;
            if (!water_ok) abort <= 1'b1;
            else           done  <= ONE << zone_id;
            if (GAP_TICKS == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (tick && cnt_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          valve_en <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
